// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared definitions for the timer APB slave: register byte offsets, the
//   highest legal register offset and the bus-sequencer state encoding.
//   No ports.
package timer_pkg;

    localparam logic [11:0] TCR      = 12'h000;
    localparam logic [11:0] TDR0     = 12'h004;
    localparam logic [11:0] TDR1     = 12'h008;
    localparam logic [11:0] TCMP0    = 12'h00C;
    localparam logic [11:0] TCMP1    = 12'h010;
    localparam logic [11:0] TIER     = 12'h014;
    localparam logic [11:0] TISR     = 12'h018;
    localparam logic [11:0] THCSR    = 12'h01C;
    localparam logic [11:0] ADDR_MAX = 12'h01C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/timer_apb_decode.sv
// timer_apb_decode
//   Pure combinational validation of an APB setup phase for the timer block.
//   Ports:
//     paddr    in  12  byte address of the transfer
//     pwrite   in   1  transfer direction (1 = write)
//     pstrb    in   4  write byte strobes
//     err      out  1  transfer is invalid (misaligned, out of range, or
//                      partial write)
//     hit_tdr0 out  1  address selects TDR0 (counter low word)
//     hit_tdr1 out  1  address selects TDR1 (counter high word)
module timer_apb_decode
    import timer_pkg::*;
(
    input  logic [11:0] paddr,
    input  logic        pwrite,
    input  logic [3:0]  pstrb,
    output logic        err,
    output logic        hit_tdr0,
    output logic        hit_tdr1
);

    // Registers are full 32-bit words only: sub-word writes are rejected.
    assign err = (paddr[1:0] != 2'b00)
               | (paddr > ADDR_MAX)
               | (pwrite & (pstrb != 4'hF));

    assign hit_tdr0 = (paddr == TDR0);
    assign hit_tdr1 = (paddr == TDR1);

endmodule

// File: rtl/timer_apb_ctrl.sv
// timer_apb_ctrl
//   APB3 slave sequencer in front of the timer register file. Each valid
//   transfer produces exactly one single-cycle register strobe in the first
//   penable cycle and completes one cycle later (one fixed wait state).
//   Optional feature macro: TIMER_APB_SNAPSHOT_EN -- makes a TDR0 then TDR1
//   read pair return a coherent 64-bit counter value.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     psel, penable, pwrite     APB3 control
//     paddr[11:0]               byte address
//     pwdata[31:0], pstrb[3:0]  write data and byte strobes
//     pready, prdata, pslverr   APB3 response (prdata registered)
//     reg_addr, reg_wr_data     register-side address and write data
//     reg_wr_en, reg_rd_en      single-cycle register strobes
//     reg_rd_data[31:0]         combinational read data from register file
//     cnt_hi[31:0]              live counter bits [63:32] (snapshot only)
//
//   state  | meaning
//   IDLE   | waiting for a setup phase; captures the transfer
//   ACCESS | first penable cycle; issues the register strobe
//   RESP   | pready high, prdata/pslverr valid
module timer_apb_ctrl
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [11:0] reg_addr,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [31:0] reg_rd_data,
    input  logic [31:0] cnt_hi
);

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic        hit0_q, hit0_d;
    logic        hit1_q, hit1_d;
    logic [31:0] prdata_q, prdata_d;

    logic        dec_err;
    logic        dec_hit0;
    logic        dec_hit1;
    logic        xfer_go;
    logic [31:0] rd_value;

    timer_apb_decode u_decode (
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pstrb    (pstrb),
        .err      (dec_err),
        .hit_tdr0 (dec_hit0),
        .hit_tdr1 (dec_hit1)
    );

    // Strobes are gated by rst so a transfer interrupted by reset never
    // reaches the register file, even in the cycle reset is sampled.
    assign xfer_go   = (state_q == ST_ACCESS) & psel & penable;
    assign reg_wr_en = xfer_go &  write_q & ~err_q & ~rst;
    assign reg_rd_en = xfer_go & ~write_q & ~err_q & ~rst;

    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign prdata      = prdata_q;
    assign pready      = (state_q == ST_RESP);
    assign pslverr     = (state_q == ST_RESP) & err_q;

`ifdef TIMER_APB_SNAPSHOT_EN
    logic [31:0] snap_hi_q, snap_hi_d;
    logic        snap_valid_q, snap_valid_d;

    always_comb begin
        snap_hi_d    = snap_hi_q;
        snap_valid_d = snap_valid_q;
        if (reg_rd_en && hit0_q) begin
            snap_hi_d    = cnt_hi;
            snap_valid_d = 1'b1;
        end else if (reg_rd_en && hit1_q) begin
            snap_valid_d = 1'b0;
        end else if (reg_wr_en && (hit0_q || hit1_q)) begin
            snap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_hi_q    <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_hi_q    <= snap_hi_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign rd_value = (hit1_q && snap_valid_q) ? snap_hi_q : reg_rd_data;
`else
    logic unused_snap;
    assign unused_snap = ^{cnt_hi, hit0_q, hit1_q};
    assign rd_value    = reg_rd_data;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        err_d    = err_q;
        hit0_d   = hit0_q;
        hit1_d   = hit1_q;
        prdata_d = prdata_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    err_d   = dec_err;
                    hit0_d  = dec_hit0;
                    hit1_d  = dec_hit1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    prdata_d = (write_q || err_q) ? 32'h0 : rd_value;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            hit0_q   <= 1'b0;
            hit1_q   <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            err_q    <= err_d;
            hit0_q   <= hit0_d;
            hit1_q   <= hit1_d;
            prdata_q <= prdata_d;
        end
    end

endmodule
